// File: rtl/logic_pkg.sv
// Shared definitions for the logic-unit arbiter: datapath width, function
// select encodings, output-register state encoding and the result payload.
package logic_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic FN_AND = 1'b0;
  localparam logic FN_XOR = 1'b1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Payload held in the output register (requester tag kept separately
  // because its width depends on the requester count).
  typedef struct packed {
    logic              fn;
    logic [DATA_W-1:0] data;
  } result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     in  N     request vector
//   ptr     in  ID_W  highest-priority index for this cycle
//   en      in  1     arbitration enable; no grant when low
//   gnt     out N     one-hot grant (or zero)
//   gnt_idx out ID_W  index of the granted request
//   gnt_any out 1     a grant was issued
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_any
);

  int unsigned idx;

  // Scan upward from ptr with wrap; the first asserted request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (en) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr) + k) % N;
        if (!gnt_any && req[ID_W'(idx)]) begin
          gnt[ID_W'(idx)] = 1'b1;
          gnt_idx         = ID_W'(idx);
          gnt_any         = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one AND/XOR logic unit between NUM_REQ requesters. A round-robin
// arbiter grants one request per cycle; the result lands in a one-entry
// output register tagged with the requester index.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req_valid/req_ready  per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b         packed operands, requester i at [i*32 +: 32]
//   req_fn               per-requester function: 1 = XOR, 0 = AND
//   out_valid/out_ready  result handshake
//   out_data, out_id, out_fn  registered result, source tag, function used
module logic_unit_arbiter
  import logic_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_fn,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_fn
);

  out_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  result_t           res_q, res_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               can_accept_c;
  logic               arb_en_c;
  logic [DATA_W-1:0]  a_sel, b_sel;
  logic               fn_sel;

  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = res_q.data;
  assign out_fn    = res_q.fn;
  assign out_id    = id_q;

  // Accept when empty, or when the held result leaves this same cycle.
  assign can_accept_c = (state_q == OUT_EMPTY) | (out_ready & out_valid);
  // Reset also forces req_ready low combinationally.
  assign arb_en_c     = can_accept_c & rst_n;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (arb_en_c),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  // Operand mux for the granted requester.
  assign a_sel  = req_a[gnt_idx*DATA_W +: DATA_W];
  assign b_sel  = req_b[gnt_idx*DATA_W +: DATA_W];
  assign fn_sel = req_fn[gnt_idx];

  // Next-state: load on handshake (drain folded in), otherwise drain or hold.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    res_d   = res_q;
    if (gnt_any) begin
      res_d.fn   = fn_sel;
      res_d.data = (fn_sel == FN_XOR) ? (a_sel ^ b_sel) : (a_sel & b_sel);
      id_d       = gnt_idx;
      state_d    = OUT_FULL;
      ptr_d      = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
    end else if (out_valid && out_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      res_q   <= res_d;
    end
  end

endmodule
